// File: rtl/imem_loader.sv
// Host-stream program loader: parses START, COUNT, data words and checksum,
// writes big-endian words into IMEM and releases the CPU with a PC load to 0.
module imem_loader #(
   parameter logic [7:0] START_BYTE     = 8'hA5,
   parameter int         MAX_WORDS      = 64,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  LD_rx_data,
   input  logic        LD_rx_valid,
   output logic        LD_rx_ready,
   output logic        LD_imem_we,
   output logic [7:0]  LD_imem_addr,
   output logic [31:0] LD_imem_data,
   output logic        LD_cpu_hold,
   output logic        LD_pc_load,
   output logic [7:0]  LD_pc_val,
   output logic        LD_done,
   output logic        LD_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
   } state_t;

   localparam int         TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [8:0] MAXW = 9'(MAX_WORDS);

   state_t        state, state_nxt;
   logic          accept, is_start, tmo_active, timeout;
   logic [7:0]    n_words, word_cnt, csum;
   logic [1:0]    byte_idx;
   logic [TW-1:0] tmo_cnt;

   assign accept     = LD_rx_valid && LD_rx_ready;
   assign is_start   = accept && (LD_rx_data == START_BYTE);
   assign tmo_active = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
   assign timeout    = tmo_active && !accept && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK) begin
      if (!RESET) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout) state_nxt = S_ERROR;
      else begin
         case (state)
            S_IDLE, S_ERROR: if (is_start) state_nxt = S_COUNT;
            S_COUNT: if (accept)
               state_nxt = (LD_rx_data == 8'd0 || {1'b0, LD_rx_data} > MAXW) ? S_ERROR : S_DATA;
            S_DATA:  if (accept && byte_idx == 2'd3) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (word_cnt + 8'd1 == n_words) ? S_CHECK : S_DATA;
            S_CHECK: if (accept) state_nxt = (LD_rx_data == csum) ? S_DONE : S_ERROR;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Error is sticky only in the sense that ERROR is left solely via a new START.
   always_comb begin
      LD_rx_ready = (state != S_WRITE);
      LD_imem_we  = (state == S_WRITE);
      LD_done     = (state == S_DONE);
      LD_pc_load  = (state == S_DONE);
      LD_pc_val   = 8'd0;
      LD_error    = (state == S_ERROR);
      LD_cpu_hold = (state != S_IDLE) && (state != S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         LD_imem_addr <= 8'd0;
         LD_imem_data <= 32'd0;
         n_words      <= 8'd0;
         word_cnt     <= 8'd0;
         csum         <= 8'd0;
         byte_idx     <= 2'd0;
         tmo_cnt      <= '0;
      end else begin
         tmo_cnt <= (tmo_active && !accept && !timeout) ? tmo_cnt + TW'(1) : '0;
         case (state)
            S_IDLE, S_ERROR: if (is_start) begin
               LD_imem_addr <= 8'd0;
               csum         <= 8'd0;
               word_cnt     <= 8'd0;
            end
            S_COUNT: if (accept) begin
               n_words  <= LD_rx_data;
               byte_idx <= 2'd0;
            end
            S_DATA: if (accept) begin
               LD_imem_data <= {LD_imem_data[23:0], LD_rx_data};
               csum         <= csum + LD_rx_data;
               byte_idx     <= byte_idx + 2'd1;
            end
            S_WRITE: begin
               LD_imem_addr <= LD_imem_addr + 8'd4;
               word_cnt     <= word_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
